adc_capture_fifo: RTL
=====================

Name: adc_capture_fifo

Overview:
- Capture stage between the 8-bit parallel ADC pins and the 6502 register bus; it replaces the free-running single-register ADC sample.
- Samples the ADC bus at a programmable decimation rate, with an optional level trigger.
- Stores samples in a small FIFO that the CPU drains through a first-word-fall-through read port.
- Runs on the same single ring-oscillator clock as the CPU.

Parameters:
- DEPTH_LOG2, 4, FIFO depth is 2**DEPTH_LOG2 entries (16).
- DIV_W, 8, width of the decimation divider.

Ports:
- clk  in  1  system clock; also drives ADC_CLK at top level.
- reset  in  1  asynchronous, active-high reset.
- adc_data  in  8  raw ADC bus, pin order already resolved by top level.
- cfg_div  in  DIV_W  decimation: one sample tick every cfg_div+1 clocks.
- cfg_thresh  in  8  trigger level, unsigned.
- cfg_trig_en  in  1  1 = wait for trigger after arm; 0 = capture immediately.
- cfg_cont  in  1  1 = continuous capture, dropping samples when full; 0 = single shot, stop when full.
- arm  in  1  one-cycle pulse: flush FIFO and start an acquisition.
- rd_pop  in  1  one-cycle pulse: discard the head entry.
- clr_ovf  in  1  one-cycle pulse: clear the overflow flag.
- rd_data  out  8  FIFO head (FWFT); valid only when empty=0.
- count  out  DEPTH_LOG2+1  number of entries held.
- empty  out  1  count==0.
- full  out  1  count==2**DEPTH_LOG2.
- overflow  out  1  sticky; set when a sample tick arrives while full in CAPTURE.
- state  out  2  IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3.

Behaviour:
- Reset (async):
  - state=IDLE, count=0, rd/wr pointers=0, divider=0, overflow=0.
  - adc_q=0, rd_data=0, empty=1, full=0.
- Input stage: adc_q <= adc_data every clk. All sample decisions use adc_q, so there is 1 clock of input latency.
- Divider:
  - div_cnt counts 0..cfg_div; tick=1 in the cycle div_cnt==cfg_div, then div_cnt wraps to 0.
  - cfg_div=0 gives a tick every clock.
  - div_cnt runs only in WAIT_TRIG and CAPTURE; it is held at 0 otherwise.
  - A cfg_div change takes effect at the next wrap.
- arm (any state):
  - Next cycle: count=0, pointers=0, div_cnt=0.
  - state=WAIT_TRIG if cfg_trig_en, else CAPTURE.
  - overflow is not affected.
  - arm wins over a same-cycle rd_pop or write; both are ignored that cycle.
- State transitions (only when arm=0):
  - IDLE: stays until arm.
  - WAIT_TRIG: on tick with adc_q>=cfg_thresh, that sample is written and state->CAPTURE. On tick below threshold, nothing is written.
  - CAPTURE, tick and not full: write adc_q.
    - In single shot, if this write makes count reach depth, state->DONE in the same edge.
  - CAPTURE, tick and full:
    - Continuous mode: sample dropped, overflow<=1, state stays CAPTURE.
    - Single shot: cannot occur, because DONE was entered.
  - CAPTURE, tick and full with a same-cycle rd_pop: the write is accepted, the pop is honoured, count is unchanged, no overflow.
  - DONE: no writes; stays until arm.
- Read port:
  - rd_data = mem[rd_ptr], combinational from registered pointer/memory, updated the clock after any write to an empty FIFO or any pop.
  - rd_pop while empty is ignored; count never underflows.
  - Pop with no write: count-1. Write with no pop: count+1.
- Pointers: DEPTH_LOG2 bits, natural wrap at 2**DEPTH_LOG2.
- clr_ovf clears overflow. If clr_ovf coincides with a new overflow event, set wins.
- Memory may be inferred as LUT RAM or BRAM; write latency is 1 clock.

Test Plan:
- Reset, then arm with trig_en=0, cont=0, div=0, adc_data ramping 0x10,0x11,… each clock -> count reaches 16, state=DONE, 16 pops read 0x10..0x1F in order (subject to the 1-clock input stage), then empty=1.
- div=3, trig_en=0, single shot -> consecutive stored samples are spaced exactly 4 clocks apart in the ramp (values differ by 4).
- trig_en=1, thresh=0x80, adc_data ramps 0x70 upward -> state stays WAIT_TRIG until adc_q>=0x80; first stored value is 0x80 (or the first tick value >=0x80 when div>0).
- cont=1, no pops, 20 ticks -> count=16, overflow=1, head=first sample. Then clr_ovf -> overflow=0. Then pop+tick together while full -> count stays 16, overflow stays 0.
- Mid-capture arm at count=7 -> next cycle count=0, empty=1, capture restarts. rd_pop on empty -> no change.
- Assert reset asynchronously mid-CAPTURE (not clock-aligned) -> all outputs immediately at reset values, state=IDLE.

Source files
------------

// File: rtl/adc_capture_fifo_if.sv
// Register-bus side of the ADC capture FIFO: configuration, control pulses and status.
// master = CPU register block, slave = capture FIFO.
`timescale 1ns/1ps
interface adc_capture_fifo_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 8
);
    logic [DIV_W-1:0]    cfg_div;
    logic [7:0]          cfg_thresh;
    logic                cfg_trig_en;
    logic                cfg_cont;
    logic                arm;
    logic                rd_pop;
    logic                clr_ovf;
    logic [7:0]          rd_data;
    logic [DEPTH_LOG2:0] count;
    logic                empty;
    logic                full;
    logic                overflow;
    logic [1:0]          state;

    modport master (
        output cfg_div, cfg_thresh, cfg_trig_en, cfg_cont, arm, rd_pop, clr_ovf,
        input  rd_data, count, empty, full, overflow, state
    );

    modport slave (
        input  cfg_div, cfg_thresh, cfg_trig_en, cfg_cont, arm, rd_pop, clr_ovf,
        output rd_data, count, empty, full, overflow, state
    );
endinterface

// File: rtl/adc_capture_fifo.sv
// ADC capture stage: decimated, optionally level-triggered sampling into a small
// first-word-fall-through FIFO drained by the CPU.
`timescale 1ns/1ps
module adc_capture_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        adc_data,
    adc_capture_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TRIG = 2'd1,
        CAPTURE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t              state_q;
    logic [7:0]          adc_q;
    logic [DIV_W-1:0]    div_cnt;
    logic [DIV_W-1:0]    div_lim;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0] count_q;
    logic [DEPTH_LOG2:0] count_next;
    logic                overflow_q;
    logic [7:0]          mem [DEPTH];

    logic running;
    logic tick;
    logic full_w;
    logic empty_w;
    logic pop_en;
    logic wr_en;
    logic ovf_evt;

    assign full_w  = (count_q == FULL_COUNT);
    assign empty_w = (count_q == '0);
    assign running = (state_q == WAIT_TRIG) || (state_q == CAPTURE);
    // div_lim is a copy of cfg_div taken at each wrap, so a divider change never cuts a period short
    assign tick    = running && (div_cnt == div_lim);
    assign pop_en  = !bus.arm && bus.rd_pop && !empty_w;

    always_comb begin
        wr_en   = 1'b0;
        ovf_evt = 1'b0;
        if (!bus.arm && tick) begin
            if (state_q == WAIT_TRIG) begin
                wr_en = (adc_q >= bus.cfg_thresh);
            end else if (state_q == CAPTURE) begin
                if (!full_w || pop_en) wr_en = 1'b1;
                else                   ovf_evt = 1'b1;
            end
        end
    end

    always_comb begin
        count_next = count_q;
        if (wr_en && !pop_en)      count_next = count_q + 1'b1;
        else if (!wr_en && pop_en) count_next = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            adc_q      <= '0;
            div_cnt    <= '0;
            div_lim    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            adc_q <= adc_data;
            if (bus.arm) begin
                state_q <= bus.cfg_trig_en ? WAIT_TRIG : CAPTURE;
                count_q <= '0;
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                div_cnt <= '0;
                div_lim <= bus.cfg_div;
            end else begin
                if (wr_en)  wr_ptr <= wr_ptr + 1'b1;
                if (pop_en) rd_ptr <= rd_ptr + 1'b1;
                count_q <= count_next;
                if (!running || tick) begin
                    div_cnt <= '0;
                    div_lim <= bus.cfg_div;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
                // Single shot stops on the very write that fills the FIFO
                case (state_q)
                    WAIT_TRIG: if (wr_en) begin
                        state_q <= (!bus.cfg_cont && count_next == FULL_COUNT) ? DONE : CAPTURE;
                    end
                    CAPTURE: if (wr_en && !bus.cfg_cont && count_next == FULL_COUNT) begin
                        state_q <= DONE;
                    end
                    default: ;
                endcase
            end
            if (ovf_evt)          overflow_q <= 1'b1;
            else if (bus.clr_ovf) overflow_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= adc_q;
    end

    assign bus.rd_data  = empty_w ? 8'h00 : mem[rd_ptr];
    assign bus.count    = count_q;
    assign bus.empty    = empty_w;
    assign bus.full     = full_w;
    assign bus.overflow = overflow_q;
    assign bus.state    = state_q;
endmodule
